coeff_buffer: RTL and testbench

COEFF_BUFFER -- requirements
Module: coeff_buffer

---
 rtl/coeff_buffer.sv | 118 +++++++++++
 tb/tb_coeff_buffer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/coeff_buffer.sv
// Coefficient store for a polynomial evaluator: loads one coefficient set
// (highest order first), locks it, then serves it through a rewindable read pointer.
module coeff_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_LINES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_last,
  input  logic                  coeff_clr,
  input  logic                  rd_en,
  input  logic                  redo,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_LINES-1:0] wr_ptr,
  output logic                  start_coeff,
  output logic                  empty,
  output logic                  rd_last
);

  localparam int DEPTH = 2 ** ADDR_LINES;
  localparam logic [ADDR_LINES-1:0] LAST_ADDR = {ADDR_LINES{1'b1}};
  localparam logic [ADDR_LINES-1:0] ADDR_ONE  = {{(ADDR_LINES-1){1'b0}}, 1'b1};

  typedef enum logic {ST_LOAD = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_LINES-1:0]   wa_q, wa_d;
  logic [ADDR_LINES-1:0]   rp_q, rp_d;
  logic [ADDR_LINES-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    empty_q, empty_d;
  logic                    mem_we_s;
  logic [ADDR_LINES-1:0]   rp_inc_s;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  assign rp_inc_s = rp_q + ADDR_ONE;

  always_comb begin
    state_d  = state_q;
    wa_d     = wa_q;
    rp_d     = rp_q;
    wr_ptr_d = wr_ptr_q;
    dout_d   = dout_q;
    empty_d  = empty_q;
    mem_we_s = 1'b0;
    if (coeff_clr) begin
      state_d  = ST_LOAD;
      wa_d     = {ADDR_LINES{1'b0}};
      rp_d     = {ADDR_LINES{1'b0}};
      wr_ptr_d = {ADDR_LINES{1'b0}};
      dout_d   = {DATA_WIDTH{1'b0}};
      empty_d  = 1'b1;
    end else begin
      if (state_q == ST_LOAD && wr_en) begin
        mem_we_s = 1'b1;
        wr_ptr_d = wa_q;
        wa_d     = wa_q + ADDR_ONE;
        empty_d  = 1'b0;
        // Lock on the flagged last coefficient or when the array is full.
        if (wr_last || wa_q == LAST_ADDR) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_LOAD;
        end
      end else begin
        mem_we_s = 1'b0;
      end
      // Reads see the pre-edge array and pre-edge wr_ptr, never this cycle's write.
      if (!empty_q) begin
        if (redo) begin
          rp_d   = {ADDR_LINES{1'b0}};
          dout_d = mem_q[0];
        end else if (rd_en && rp_q < wr_ptr_q) begin
          rp_d   = rp_inc_s;
          dout_d = mem_q[rp_inc_s];
        end else begin
          rp_d   = rp_q;
        end
      end else begin
        rp_d = rp_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      wa_q     <= {ADDR_LINES{1'b0}};
      rp_q     <= {ADDR_LINES{1'b0}};
      wr_ptr_q <= {ADDR_LINES{1'b0}};
      dout_q   <= {DATA_WIDTH{1'b0}};
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      wa_q     <= wa_d;
      rp_q     <= rp_d;
      wr_ptr_q <= wr_ptr_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
    end
  end

  // The array holds no reset; empty/wr_ptr gate every read of it.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wa_q] <= din;
    end
  end

  assign dout        = dout_q;
  assign wr_ptr      = wr_ptr_q;
  assign start_coeff = (state_q == ST_LOCKED);
  assign empty       = empty_q;
  assign rd_last     = !empty_q && (rp_q == wr_ptr_q);

endmodule

// File: tb/tb_coeff_buffer.sv
// Directed bench for coeff_buffer: expected dout values are queued when a read
// is driven and popped when the registered output appears.
module tb_coeff_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, wr_last, coeff_clr, rd_en, redo;
  logic [15:0] din;
  logic [15:0] dout;
  logic [3:0]  wr_ptr;
  logic        start_coeff, empty, rd_last;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  coeff_buffer #(.DATA_WIDTH(16), .ADDR_LINES(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .wr_last(wr_last),
    .coeff_clr(coeff_clr), .rd_en(rd_en), .redo(redo), .dout(dout),
    .wr_ptr(wr_ptr), .start_coeff(start_coeff), .empty(empty), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given controls, then sample #1 after the edge.
  task automatic cyc(input logic w, input logic [15:0] d, input logic l,
                     input logic c, input logic r, input logic rw);
    wr_en = w; din = d; wr_last = l; coeff_clr = c; rd_en = r; redo = rw;
    @(posedge clk);
    #1;
    wr_en = 1'b0; din = 16'h0; wr_last = 1'b0; coeff_clr = 1'b0; rd_en = 1'b0; redo = 1'b0;
  endtask

  task automatic rd_step(input string tag, input logic r, input logic rw,
                         input logic [15:0] e, input logic exp_last);
    logic [15:0] e_pop;
    exp_q.push_back(e);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, r, rw);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e_pop = exp_q.pop_front();
      chk({tag, "_dout"}, 32'(dout), 32'(e_pop));
    end
    chk({tag, "_rd_last"}, 32'(rd_last), 32'(exp_last));
  endtask

  task automatic chk_state(input string tag, input logic [3:0] wp,
                           input logic st, input logic em);
    chk({tag, "_wr_ptr"}, 32'(wr_ptr), 32'(wp));
    chk({tag, "_start"}, 32'(start_coeff), 32'(st));
    chk({tag, "_empty"}, 32'(empty), 32'(em));
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; din = 16'h0; wr_last = 1'b0; coeff_clr = 1'b0; rd_en = 1'b0; redo = 1'b0;
    #12;
    chk_state("reset", 4'd0, 1'b0, 1'b1);
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_rd_last", 32'(rd_last), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reads while empty are ignored
    rd_step("empty_redo", 1'b1, 1'b1, 16'h0000, 1'b0);

    // Three-coefficient load
    cyc(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("load1", 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("load2", 4'd1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state("load3", 4'd2, 1'b1, 1'b0);

    // Readback with saturation
    rd_step("rd_redo", 1'b0, 1'b1, 16'h0003, 1'b0);
    rd_step("rd_1", 1'b1, 1'b0, 16'h0002, 1'b0);
    rd_step("rd_2", 1'b1, 1'b0, 16'h0001, 1'b1);
    rd_step("rd_sat", 1'b1, 1'b0, 16'h0001, 1'b1);

    // Writes while locked are ignored
    cyc(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("locked_wr", 4'd2, 1'b1, 1'b0);
    rd_step("locked_redo", 1'b0, 1'b1, 16'h0003, 1'b0);

    // redo beats rd_en at rp=2
    rd_step("pre_a", 1'b1, 1'b0, 16'h0002, 1'b0);
    rd_step("pre_b", 1'b1, 1'b0, 16'h0001, 1'b1);
    rd_step("redo_wins", 1'b1, 1'b1, 16'h0003, 1'b0);

    // coeff_clr beats wr_en
    cyc(1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_state("clr_wr", 4'd0, 1'b0, 1'b1);
    chk("clr_dout", 32'(dout), 32'h0);
    rd_step("clr_redo", 1'b0, 1'b1, 16'h0000, 1'b0);

    // Full 16-entry load without wr_last
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 14) chk_state("full15", 4'd14, 1'b0, 1'b0);
    end
    chk_state("full16", 4'd15, 1'b1, 1'b0);
    cyc(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("full17", 4'd15, 1'b1, 1'b0);
    rd_step("full_redo", 1'b0, 1'b1, 16'h0100, 1'b0);
    for (int i = 1; i < 16; i++) begin
      rd_step("full_rd", 1'b1, 1'b0, 16'h0100 + 16'(i), (i == 15));
    end
    rd_step("full_sat", 1'b1, 1'b0, 16'h010F, 1'b1);

    // Reset mid-load abandons the set
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("mid_load", 4'd1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 4'd0, 1'b0, 1'b1);
    chk("async_rst_dout", 32'(dout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state("reload", 4'd2, 1'b1, 1'b0);
    rd_step("reload_redo", 1'b0, 1'b1, 16'h000A, 1'b0);
    rd_step("reload_rd", 1'b1, 1'b0, 16'h000B, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
